mem_word_fetch: RTL and testbench
=================================

MEM_WORD_FETCH -- requirements
Module: mem_word_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles per byte before the fetch aborts.
REQ-003 clk  input  1  single system clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one 24-bit word fetch; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  byte address of the word's least-significant byte; sampled with start.
REQ-007 mem_addr  output  ADDR_W  byte address presented to memory.
REQ-008 mem_rd  output  1  read strobe; high throughout FETCH.
REQ-009 mem_rdata  input  8  read byte; valid when mem_ready is high.
REQ-010 mem_ready  input  1  memory completion; qualified by mem_rd.
REQ-011 word_out  output  24  assembled word; drives data_register data_in.
REQ-012 word_valid  output  1  one-cycle pulse; drives data_register enable.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout  output  1  one-cycle pulse when a fetch aborts.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH, DONE and ABORT.
REQ-016 IDLE with start=1 -> FETCH; latch base_addr; clear the byte index (0..2) and the wait counter.
REQ-017 In FETCH: mem_rd=1; mem_addr = latched base + index, modulo 2^ADDR_W (0xFFFF+1 wraps to 0x0000).
REQ-018 FETCH with mem_ready=1: store mem_rdata into the shadow register at bits [8*index+7 : 8*index] (little-endian); increment index; clear the wait counter.
REQ-019 Capture of byte index 2 SHALL transition to DONE; otherwise FETCH continues with the next address on the next cycle.
REQ-020 FETCH with mem_ready=0: increment the wait counter; when the counter reaches TIMEOUT -> ABORT.
REQ-021 mem_ready=1 on the same edge the counter would reach TIMEOUT: the capture wins and the counter clears.
REQ-022 DONE lasts one cycle: copy the shadow register to word_out on entry; word_valid=1; next state IDLE.
REQ-023 ABORT lasts one cycle: timeout=1; word_valid=0; word_out unchanged; shadow discarded; next state IDLE.
REQ-024 word_out SHALL change only on entry to DONE and SHALL hold its value between fetches.
REQ-025 Zero-wait latency: start sampled at edge N; FETCH on cycles N+1..N+3; word_valid high in cycle N+4; busy low from N+5.
REQ-026 A new start SHALL be accepted in the cycle after DONE or ABORT, with no back-to-back overlap.
REQ-027 start outside IDLE SHALL be ignored and not queued.
REQ-028 mem_ready while mem_rd=0 SHALL be ignored.
REQ-029 mem_rd, word_valid and timeout SHALL be registered (glitch-free) outputs.

Reset
REQ-030 reset=1 at a clock edge forces: state IDLE; index, wait counter, shadow and word_out = 0; mem_addr = 0; mem_rd, word_valid, busy and timeout = 0.
REQ-031 reset SHALL take priority over start and mem_ready on the same edge.
REQ-032 reset mid-fetch SHALL abort silently, with no word_valid and no timeout pulse.

Structure
REQ-033 A shared package SHALL hold the state encoding (2-bit enum: IDLE, FETCH, DONE, ABORT), WORD_W=24 and BYTES_PER_WORD=3.
REQ-034 The wait counter SHALL be one sub-module, wait_timer: clear input, count-enable input, TIMEOUT parameter, expired output.
REQ-035 word_out SHALL connect directly to data_register data_in, and word_valid directly to data_register enable.

Verification
REQ-036 Zero-wait fetch: base=0x0010, memory returns 0xAA, 0xBB, 0xCC on consecutive cycles -> word_out=0xCCBBAA with word_valid in cycle N+4.
REQ-037 Wrap: base=0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000; bytes 0x01, 0x02, 0x03 -> word_out=0x030201.
REQ-038 Wait states: 3 idle cycles before each byte, data 0x11, 0x22, 0x33 -> word_out=0x332211 with word_valid in cycle N+13; timeout stays 0.
REQ-039 Timeout: mem_ready held at 0 after byte 0 -> ABORT after 15 wait cycles; timeout pulses once; word_out keeps its prior value.
REQ-040 Reset asserted during byte 1 -> next cycle IDLE with all outputs 0; no word_valid; a subsequent start fetches correctly.
REQ-041 start pulsed during FETCH -> ignored; exactly one word_valid pulse per accepted start.

Source files
------------

// File: rtl/mem_word_fetch_pkg.sv
// Shared types and constants for the 24-bit little-endian word fetcher.
package mem_word_fetch_pkg;

    localparam int unsigned WORD_W         = 24;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDone  = 2'd2,
        StAbort = 2'd3
    } state_e;

endpackage

// File: rtl/mem_word_fetch_wait_timer.sv
// Per-byte wait counter; flags the cycle in which one more idle wait would hit TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expired is raised on the edge whose increment would reach TIMEOUT.
    assign expired = count_en && !clear && (cnt_q == CntW'(TIMEOUT - 1));

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_word_fetch.sv
// Fetches three consecutive bytes from a byte-wide memory and assembles a 24-bit
// little-endian word. word_out/word_valid feed a downstream data_register directly
// (data_in / enable), so word_out only changes on a successful fetch.
module mem_word_fetch
    import mem_word_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              busy,
    output logic              timeout
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   shadow_q, shadow_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                mem_rd_q, word_valid_q, timeout_q;
    logic                wait_clear, wait_en, wait_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (wait_expired)
    );

    // Next-state logic: sequencing, byte capture and word hand-off.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        word_d     = word_q;
        wait_clear = 1'b0;
        wait_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFetch;
                    base_d     = base_addr;
                    idx_d      = '0;
                    shadow_d   = '0;
                    wait_clear = 1'b1;
                end
            end
            StFetch: begin
                if (mem_ready) begin
                    case (idx_q)
                        2'd0:    shadow_d[7:0]   = mem_rdata;
                        2'd1:    shadow_d[15:8]  = mem_rdata;
                        default: shadow_d[23:16] = mem_rdata;
                    endcase
                    idx_d      = idx_q + 2'd1;
                    wait_clear = 1'b1;
                    if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        // Last byte comes straight from the bus, not the shadow flops.
                        state_d = StDone;
                        word_d  = shadow_d;
                    end
                end else begin
                    wait_en = 1'b1;
                    if (wait_expired) begin
                        state_d = StAbort;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StAbort: begin
                state_d  = StIdle;
                shadow_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered strobes; outputs decode the next state so they are flop-driven.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            base_q       <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            word_q       <= '0;
            mem_rd_q     <= 1'b0;
            word_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            word_q       <= word_d;
            mem_rd_q     <= (state_d == StFetch);
            word_valid_q <= (state_d == StDone);
            timeout_q    <= (state_d == StAbort);
        end
    end

    assign mem_addr   = base_q + ADDR_W'(idx_q);
    assign mem_rd     = mem_rd_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_word_fetch.sv
// Directed bench for mem_word_fetch: zero-wait, wrap, wait states, timeout boundary,
// reset mid-fetch and start-while-busy.
module tb_mem_word_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [23:0] word_out;
    logic        word_valid;
    logic        busy;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    mem_word_fetch #(
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // One fetch with 'waits' not-ready cycles before each byte; checks addresses and timing.
    task automatic run_fetch(input string tag, input logic [15:0] base, input logic [23:0] data,
                             input int waits);
        logic [15:0] a;
        start     = 1'b1;
        base_addr = base;
        mem_ready = 1'b0;
        tick();
        start     = 1'b0;
        base_addr = 16'h0;
        for (int i = 0; i < 3; i++) begin
            a = base + 16'(i);
            for (int w = 0; w < waits; w++) begin
                mem_ready = 1'b0;
                tick();
            end
            check_eq({tag, "_addr"}, 32'(mem_addr), 32'(a));
            check_eq({tag, "_rd"}, 32'(mem_rd), 32'd1);
            mem_ready = 1'b1;
            mem_rdata = data[8*i +: 8];
            tick();
            mem_ready = 1'b0;
        end
        check_eq({tag, "_valid"}, 32'(word_valid), 32'd1);
        check_eq({tag, "_word"}, 32'(word_out), 32'(data));
        check_eq({tag, "_to"}, 32'(timeout), 32'd0);
        check_eq({tag, "_rd_done"}, 32'(mem_rd), 32'd0);
        tick();
        check_eq({tag, "_valid_off"}, 32'(word_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_hold"}, 32'(word_out), 32'(data));
    endtask

    int vcount;
    int tcount;

    initial begin
        reset     = 1'b1;
        start     = 1'b1;
        base_addr = 16'h1234;
        mem_ready = 1'b1;
        mem_rdata = 8'h5A;
        repeat (3) tick();
        // Reset beats start and mem_ready on the same edge.
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_word", 32'(word_out), 32'd0);
        check_eq("rst_valid", 32'(word_valid), 32'd0);
        check_eq("rst_to", 32'(timeout), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        // mem_ready while idle is ignored.
        repeat (3) tick();
        check_eq("idle_ready_busy", 32'(busy), 32'd0);
        check_eq("idle_ready_valid", 32'(word_valid), 32'd0);
        mem_ready = 1'b0;

        run_fetch("zw", 16'h0010, 24'hCCBBAA, 0);
        run_fetch("wrap", 16'hFFFE, 24'h030201, 0);
        run_fetch("wait3", 16'h0040, 24'h332211, 3);
        // 14 waits then ready: capture lands just before the counter would expire.
        run_fetch("edge14", 16'h0200, 24'h998877, 14);
        run_fetch("wait3b", 16'h0040, 24'h332211, 3);

        // Timeout: byte 0 arrives, then memory stalls.
        start     = 1'b1;
        base_addr = 16'h0100;
        tick();
        start     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h55;
        tick();
        mem_ready = 1'b0;
        tcount    = 0;
        for (int w = 0; w < 15; w++) begin
            if (w == 0) check_eq("to_addr1", 32'(mem_addr), 32'h0101);
            tcount += int'(timeout);
            tick();
        end
        check_eq("to_early", 32'(tcount), 32'd0);
        check_eq("to_pulse", 32'(timeout), 32'd1);
        check_eq("to_valid", 32'(word_valid), 32'd0);
        check_eq("to_word", 32'(word_out), 32'h332211);
        check_eq("to_rd", 32'(mem_rd), 32'd0);
        tick();
        check_eq("to_off", 32'(timeout), 32'd0);
        check_eq("to_idle", 32'(busy), 32'd0);
        check_eq("to_hold", 32'(word_out), 32'h332211);

        // Reset during byte 1.
        start     = 1'b1;
        base_addr = 16'h0300;
        tick();
        start     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h12;
        tick();
        reset     = 1'b1;
        mem_rdata = 8'h34;
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_rd", 32'(mem_rd), 32'd0);
        check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
        check_eq("mid_rst_word", 32'(word_out), 32'd0);
        check_eq("mid_rst_valid", 32'(word_valid), 32'd0);
        check_eq("mid_rst_to", 32'(timeout), 32'd0);
        tick();
        check_eq("mid_rst_valid2", 32'(word_valid), 32'd0);
        run_fetch("post_rst", 16'h0400, 24'hC0FFEE, 1);

        // start pulsed during FETCH must not restart or queue a fetch.
        start     = 1'b1;
        base_addr = 16'h0500;
        tick();
        vcount = 0;
        for (int c = 1; c <= 10; c++) begin
            vcount += int'(word_valid);
            if (c <= 3) check_eq("ign_addr", 32'(mem_addr), 32'h0500 + 32'(c - 1));
            if (c == 4) check_eq("ign_word", 32'(word_out), 32'h665544);
            start     = (c == 1 || c == 2);
            base_addr = 16'h0900;
            mem_ready = (c <= 3);
            mem_rdata = 8'h44 + 8'((c - 1) * 17);
            tick();
        end
        check_eq("ign_pulses", 32'(vcount), 32'd1);
        check_eq("ign_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
